recip_result_buf: RTL and testbench
===================================

# recip_result_buf

Registered output stage placed directly downstream of the combinational `recip_x` reciprocal unit. It accepts each result word, its class flags and its exception vector over a valid/ready handshake, then buffers up to two results in order. It presents them to the consumer with registered outputs, breaking the long combinational path out of `recip_x`. It also keeps IEEE 754 sticky status flags and a saturating count of results that raised any exception.

## Interface
Parameters:
- `NEXP`, default 5: exponent width. Default is binary16; use 8 for binary32.
- `NSIG`, default 10: significand field width. Use 23 for binary32.
- `CNTW`, default 16: width of the exception counter.
- `NTYPES` and `NEXCEPTIONS` come from `ieee-754-flags.vh`. Exception bit indices are the header's `invalid`, `divideByZero`, `overflow`, `underflow` and `inexact`.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous reset, active-high.
- `in_valid`, in, 1: upstream result is present.
- `in_ready`, out, 1: buffer can accept a result.
- `in_r`, in, NEXP+NSIG+1: reciprocal result word from `recip_x`.
- `in_flags`, in, NTYPES: result class flags.
- `in_exc`, in, NEXCEPTIONS: exception vector raised by this result.
- `out_valid`, out, 1: head entry is valid.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_r`, out, NEXP+NSIG+1: head result word.
- `out_flags`, out, NTYPES: head class flags.
- `out_exc`, out, NEXCEPTIONS: head exception vector.
- `clr_status`, in, 1: synchronous clear of `status` and `exc_count`.
- `status`, out, NEXCEPTIONS: sticky OR of the exception vectors of all accepted results.
- `exc_count`, out, CNTW: number of accepted results with `in_exc != 0`. Saturates at all-ones.

## Operation
- Storage is two entries, `head` and `tail`. Each entry holds {r, flags, exc}.
- Occupancy states:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: `out_valid`=1, `in_ready`=1.
  - FULL: `out_valid`=1, `in_ready`=0.
- Handshakes: push = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- Transitions:
  - EMPTY + push goes to ONE; the data is written to `head`.
  - ONE + push only goes to FULL; the data is written to `tail`.
  - ONE + pop only goes to EMPTY.
  - ONE + push + pop stays in ONE; the new data is written to `head`.
  - FULL + pop goes to ONE; `tail` moves to `head`.
  - FULL with no pop holds.
- Results leave in strict acceptance order. None is dropped or duplicated.
- Upstream rule: while `in_valid`=1 and `in_ready`=0, upstream holds its inputs stable. `in_*` data is sampled only on a push.
- `out_*` ports are driven directly from `head` registers. There is no combinational path from `in_*` to `out_*`.
- `in_ready` is a pure function of the occupancy register. It never depends on `out_ready` in the same cycle.
- Status update on a push: `status <= status | in_exc`. The counter increments by 1 if `in_exc != 0` and it is below all-ones.
- `clr_status` has priority over accumulation, but a push in the same cycle still counts:
  - `status <= in_exc` if there is a push, else 0.
  - `exc_count <=` 1 if there is a push with `in_exc != 0`, else 0.
- `status` and `exc_count` are unaffected by pops.

## Timing
- Latency: a result pushed at edge N appears on `out_*` with `out_valid`=1 after edge N. That is one cycle, provided the buffer was EMPTY or the head popped at N.
- Throughput: one result per cycle when `out_ready` is held at 1.
- `status` and `exc_count` reflect a push made at edge N after edge N.
- Reset (async, takes effect immediately):
  - `out_valid`=0 and occupancy is EMPTY.
  - `status`=0 and `exc_count`=0.
  - `out_r`, `out_flags` and `out_exc` are 0.
  - `in_ready`=0 while `rst`=1. It rises after the first `clk` edge following `rst` deassertion.
- Reset mid-operation discards buffered entries with no output pulse.

## Test plan
- Reset: assert `rst` while FULL.
  - `out_valid` drops immediately, and `status`=0, `exc_count`=0.
  - `in_ready`=0 during reset and becomes 1 one edge after release.
- Pass-through, binary16: push `in_r`=16'h3518 with only the `inexact` bit set and `out_ready`=1.
  - Next cycle: `out_valid`=1, `out_r`=16'h3518.
  - `status` has only `inexact` set, and `exc_count`=1.
- Backpressure: hold `out_ready`=0 and offer 16'h3c00, 16'hbc00, 16'h7c00 back-to-back.
  - The first two are accepted and `in_ready`=0 after the second.
  - 16'h7c00 waits until `out_ready`=1 frees an entry.
  - Output order is 3c00, bc00, 7c00.
- Sticky behaviour: push 16'h7c00 with `divideByZero` set, then 16'h3c00 with `in_exc`=0.
  - `status` keeps only `divideByZero`, and `exc_count` stays 1.
- Clear with concurrent push: assert `clr_status` in the same cycle as a push of 16'h7e00 with `invalid` set, starting from `status`=`inexact` and `exc_count`=5.
  - Next cycle: `status`=`invalid` only, and `exc_count`=1.
- Saturation and binary32: set `CNTW`=2, `NEXP`=8, `NSIG`=23, then push five results 32'h3ea2f983, each with `inexact` set.
  - `exc_count` reaches 3 and stays at 3.
  - All five appear on `out_r` in order.

Source files
------------

// File: rtl/recip_result_buf_if.sv
// Handshake and status bundle between recip_x, the result buffer and its consumer.
// slave is the buffer's view; master is the view of whatever drives it.
interface recip_result_buf_if #(
  parameter int NEXP        = 5,
  parameter int NSIG        = 10,
  parameter int CNTW        = 16,
  parameter int NTYPES      = 7,
  parameter int NEXCEPTIONS = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NEXP+NSIG:0]     in_r;
  logic [NTYPES-1:0]      in_flags;
  logic [NEXCEPTIONS-1:0] in_exc;
  logic                   out_valid;
  logic                   out_ready;
  logic [NEXP+NSIG:0]     out_r;
  logic [NTYPES-1:0]      out_flags;
  logic [NEXCEPTIONS-1:0] out_exc;
  logic                   clr_status;
  logic [NEXCEPTIONS-1:0] status;
  logic [CNTW-1:0]        exc_count;

  modport slave (
    input  in_valid, in_r, in_flags, in_exc, out_ready, clr_status,
    output in_ready, out_valid, out_r, out_flags, out_exc, status, exc_count
  );

  modport master (
    output in_valid, in_r, in_flags, in_exc, out_ready, clr_status,
    input  in_ready, out_valid, out_r, out_flags, out_exc, status, exc_count
  );
endinterface

// File: rtl/recip_result_buf.sv
// Two-entry registered skid buffer behind recip_x, with sticky IEEE exception
// status and a saturating count of results that raised any exception.
module recip_result_buf #(
  parameter int NEXP        = 5,
  parameter int NSIG        = 10,
  parameter int CNTW        = 16,
  parameter int NTYPES      = 7,
  parameter int NEXCEPTIONS = 5
) (
  input  logic              clk,
  input  logic              rst,
  recip_result_buf_if.slave bus
);
  localparam int W = NEXP + NSIG + 1;

  typedef struct packed {
    logic [W-1:0]           r;
    logic [NTYPES-1:0]      flags;
    logic [NEXCEPTIONS-1:0] exc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  occ_e                   r_state, w_next;
  entry_t                 r_head, r_tail, w_in;
  logic                   r_live;
  logic                   w_in_ready, w_out_valid, w_push, w_pop;
  logic                   w_ld_head_in, w_ld_head_tail, w_ld_tail;
  logic [NEXCEPTIONS-1:0] r_status;
  logic [CNTW-1:0]        r_cnt;
  logic                   w_exc_any;

  assign w_in      = '{r: bus.in_r, flags: bus.in_flags, exc: bus.in_exc};
  assign w_exc_any = |bus.in_exc;
  assign w_push    = bus.in_valid & w_in_ready;
  assign w_pop     = w_out_valid & bus.out_ready;

  // r_live holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_in_ready     = 1'b0;
    w_out_valid    = 1'b0;
    w_ld_head_in   = 1'b0;
    w_ld_head_tail = 1'b0;
    w_ld_tail      = 1'b0;
    case (r_state)
      EMPTY: begin
        w_in_ready = r_live;
        if (w_push) begin
          w_next       = ONE;
          w_ld_head_in = 1'b1;
        end
      end
      ONE: begin
        w_in_ready  = r_live;
        w_out_valid = 1'b1;
        case ({w_push, w_pop})
          2'b10: begin
            w_next    = FULL;
            w_ld_tail = 1'b1;
          end
          2'b01: w_next = EMPTY;
          2'b11: w_ld_head_in = 1'b1;
          default: ;
        endcase
      end
      FULL: begin
        w_out_valid = 1'b1;
        if (w_pop) begin
          w_next         = ONE;
          w_ld_head_tail = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_ld_head_in)        r_head <= w_in;
      else if (w_ld_head_tail) r_head <= r_tail;
      if (w_ld_tail)           r_tail <= w_in;
    end
  end

  // Clear wins over accumulation, but a same-cycle push still lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
      r_cnt    <= '0;
    end else if (bus.clr_status) begin
      r_status <= w_push ? bus.in_exc : '0;
      r_cnt    <= (w_push && w_exc_any) ? CNTW'(1) : '0;
    end else if (w_push) begin
      r_status <= r_status | bus.in_exc;
      if (w_exc_any && (r_cnt != '1)) r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_r     = r_head.r;
  assign bus.out_flags = r_head.flags;
  assign bus.out_exc   = r_head.exc;
  assign bus.status    = r_status;
  assign bus.exc_count = r_cnt;
endmodule

// File: tb/tb_recip_result_buf.sv
// Bench for recip_result_buf: queue-based reference model for a binary16 instance,
// directed scenarios, and a binary32 instance with a 2-bit saturating counter.
module tb_recip_result_buf;
  localparam int NT = 7;
  localparam int NE = 5;
  localparam logic [NE-1:0] X_INV = 5'b10000;
  localparam logic [NE-1:0] X_DZ  = 5'b01000;
  localparam logic [NE-1:0] X_NX  = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  recip_result_buf_if #(.NEXP(5), .NSIG(10), .CNTW(16), .NTYPES(NT), .NEXCEPTIONS(NE)) a_if ();
  recip_result_buf #(.NEXP(5), .NSIG(10), .CNTW(16), .NTYPES(NT), .NEXCEPTIONS(NE))
    dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));

  recip_result_buf_if #(.NEXP(8), .NSIG(23), .CNTW(2), .NTYPES(NT), .NEXCEPTIONS(NE)) b_if ();
  recip_result_buf #(.NEXP(8), .NSIG(23), .CNTW(2), .NTYPES(NT), .NEXCEPTIONS(NE))
    dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: an ordered queue of accepted results plus status/counter.
  typedef struct {
    logic [15:0]   r;
    logic [NT-1:0] f;
    logic [NE-1:0] e;
  } ent_t;

  ent_t          q[$];
  logic [NE-1:0] m_st   = '0;
  int            m_cnt  = 0;
  bit            m_live = 1'b0;
  bit            m_took = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit push, pop;
    if (rst) begin
      q.delete();
      m_st   = '0;
      m_cnt  = 0;
      m_live = 1'b0;
      m_took = 1'b0;
    end else begin
      push = a_if.in_valid && m_live && (q.size() < 2);
      pop  = (q.size() > 0) && a_if.out_ready;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{a_if.in_r, a_if.in_flags, a_if.in_exc});
      if (a_if.clr_status) begin
        m_st  = push ? a_if.in_exc : '0;
        m_cnt = (push && a_if.in_exc != 0) ? 1 : 0;
      end else if (push) begin
        m_st = m_st | a_if.in_exc;
        if (a_if.in_exc != 0 && m_cnt < 65535) m_cnt++;
      end
      m_took = push;
      m_live = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("a_out_valid", a_if.out_valid, 64'(q.size() > 0));
    chk("a_in_ready", a_if.in_ready, 64'(m_live && q.size() < 2));
    if (q.size() > 0) begin
      chk("a_out_r", a_if.out_r, q[0].r);
      chk("a_out_flags", a_if.out_flags, q[0].f);
      chk("a_out_exc", a_if.out_exc, q[0].e);
    end
    chk("a_status", a_if.status, m_st);
    chk("a_exc_count", a_if.exc_count, 64'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic a_drive(input logic v, input logic [15:0] r, input logic [NE-1:0] e);
    a_if.in_valid = v;
    a_if.in_r     = r;
    a_if.in_flags = r[6:0];
    a_if.in_exc   = e;
  endtask

  int cnt_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    a_if.in_valid = 1'b0; a_if.in_r = '0; a_if.in_flags = '0; a_if.in_exc = '0;
    a_if.out_ready = 1'b0; a_if.clr_status = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_r = '0; b_if.in_flags = '0; b_if.in_exc = '0;
    b_if.out_ready = 1'b1; b_if.clr_status = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_in_ready", a_if.in_ready, 0);
    chk("rst_out_r", a_if.out_r, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("rel_in_ready_low", a_if.in_ready, 0);
    tick();
    chk("rel_in_ready_high", a_if.in_ready, 1);

    // Pass-through
    a_if.out_ready = 1'b1;
    a_drive(1'b1, 16'h3518, X_NX);
    tick();
    a_drive(1'b0, 16'h0, '0);
    chk("pt_out_valid", a_if.out_valid, 1);
    chk("pt_out_r", a_if.out_r, 16'h3518);
    chk("pt_status", a_if.status, X_NX);
    chk("pt_count", a_if.exc_count, 1);
    tick();

    // Backpressure
    a_if.out_ready = 1'b0;
    a_drive(1'b1, 16'h3c00, '0);
    tick();
    a_drive(1'b1, 16'hbc00, '0);
    tick();
    chk("bp_full_ready", a_if.in_ready, 0);
    a_drive(1'b1, 16'h7c00, '0);
    tick();
    chk("bp_wait_ready", a_if.in_ready, 0);
    chk("bp_head0", a_if.out_r, 16'h3c00);
    a_if.out_ready = 1'b1;
    tick();
    chk("bp_head1", a_if.out_r, 16'hbc00);
    tick();
    chk("bp_head2", a_if.out_r, 16'h7c00);
    a_drive(1'b0, 16'h0, '0);
    tick();
    chk("bp_drained", a_if.out_valid, 0);

    // Reset while FULL
    a_if.out_ready = 1'b0;
    a_drive(1'b1, 16'h1111, X_DZ);
    tick();
    a_drive(1'b1, 16'h2222, X_NX);
    tick();
    a_drive(1'b0, 16'h0, '0);
    chk("rf_full", a_if.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rf_out_valid", a_if.out_valid, 0);
    chk("rf_in_ready", a_if.in_ready, 0);
    chk("rf_status", a_if.status, 0);
    chk("rf_count", a_if.exc_count, 0);
    tick();
    rst = 1'b0;
    chk("rf_rel_low", a_if.in_ready, 0);
    tick();
    chk("rf_rel_high", a_if.in_ready, 1);
    chk("rf_discarded", a_if.out_valid, 0);

    // Sticky
    a_if.out_ready = 1'b1;
    a_drive(1'b1, 16'h7c00, X_DZ);
    tick();
    a_drive(1'b1, 16'h3c00, '0);
    tick();
    a_drive(1'b0, 16'h0, '0);
    chk("st_status", a_if.status, X_DZ);
    chk("st_count", a_if.exc_count, 1);
    chk("st_out_r", a_if.out_r, 16'h3c00);
    tick();

    // Clear with concurrent push
    a_if.clr_status = 1'b1;
    a_drive(1'b1, 16'h4000, X_NX);
    tick();
    a_if.clr_status = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("cl_pre_status", a_if.status, X_NX);
    chk("cl_pre_count", a_if.exc_count, 5);
    a_if.clr_status = 1'b1;
    a_drive(1'b1, 16'h7e00, X_INV);
    tick();
    a_if.clr_status = 1'b0;
    a_drive(1'b0, 16'h0, '0);
    chk("cl_status", a_if.status, X_INV);
    chk("cl_count", a_if.exc_count, 1);
    chk("cl_out_r", a_if.out_r, 16'h7e00);
    tick();

    // Saturation, binary32
    for (int i = 0; i < 5; i++) begin
      b_if.in_valid = 1'b1;
      b_if.in_r     = 32'h3ea2f983;
      b_if.in_flags = 7'(i);
      b_if.in_exc   = X_NX;
      tick();
      chk("b_count", b_if.exc_count, 64'(cnt_exp[i]));
      chk("b_out_valid", b_if.out_valid, 1);
      chk("b_out_r", b_if.out_r, 32'h3ea2f983);
      chk("b_order", b_if.out_flags, 64'(i));
    end
    b_if.in_valid = 1'b0;
    tick();
    chk("b_drained", b_if.out_valid, 0);
    chk("b_count_hold", b_if.exc_count, 3);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (!(a_if.in_valid && !m_took)) begin
        a_if.in_valid = ($urandom_range(0, 3) != 0);
        a_if.in_r     = 16'($urandom);
        a_if.in_flags = 7'($urandom);
        a_if.in_exc   = ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'h0;
      end
      a_if.out_ready  = ($urandom_range(0, 2) != 0);
      a_if.clr_status = ($urandom_range(0, 31) == 0);
      tick();
    end
    a_if.in_valid   = 1'b0;
    a_if.clr_status = 1'b0;
    a_if.out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("final_empty", a_if.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
